// File: rtl/conn_monitor_types_pkg.sv
// Types and constants shared between the UART event decoder and the connection monitor.
package conn_monitor_types_pkg;

  typedef enum logic {
    EVT_CONNECT    = 1'b0,
    EVT_DISCONNECT = 1'b1
  } conn_event_t;

  typedef enum logic [2:0] {
    D_IDLE,
    D_KEYWORD,
    D_MAC,
    D_EOL,
    D_DISCARD
  } conn_decoder_state_t;

  localparam logic [7:0] ASCII_PLUS  = 8'h2B;
  localparam logic [7:0] ASCII_COLON = 8'h3A;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;

  localparam int MAC_CHARS = 17;

  // Keyword characters following the leading '+'.
  function automatic logic [7:0] kw_conn_char(input logic [2:0] idx);
    case (idx)
      3'd0:    return 8'h43; // C
      3'd1:    return 8'h4F; // O
      3'd2:    return 8'h4E; // N
      3'd3:    return 8'h4E; // N
      3'd4:    return ASCII_COLON;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] kw_disc_char(input logic [2:0] idx);
    case (idx)
      3'd0:    return 8'h44; // D
      3'd1:    return 8'h49; // I
      3'd2:    return 8'h53; // S
      3'd3:    return 8'h43; // C
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic is_sep_pos(input logic [4:0] pos);
    return (pos == 5'd2) || (pos == 5'd5) || (pos == 5'd8) ||
           (pos == 5'd11) || (pos == 5'd14);
  endfunction

endpackage

// File: rtl/conn_event_decoder_hex.sv
// Combinational ASCII hex digit decoder; accepts upper- and lower-case letters.
module hex_ascii_to_nibble (
  input  logic [7:0] char_i,
  output logic [3:0] nibble_o,
  output logic       is_hex_o
);

  always_comb begin
    nibble_o = 4'h0;
    is_hex_o = 1'b0;
    if (char_i >= 8'h30 && char_i <= 8'h39) begin
      nibble_o = char_i[3:0];
      is_hex_o = 1'b1;
    end else if ((char_i >= 8'h41 && char_i <= 8'h46) ||
                 (char_i >= 8'h61 && char_i <= 8'h66)) begin
      // 'A'/'a' have low nibble 1, so adding 9 yields 10..15
      nibble_o = char_i[3:0] + 4'd9;
      is_hex_o = 1'b1;
    end
  end

endmodule

// File: rtl/conn_event_decoder.sv
// Decodes "+CONN:<mac>" / "+DISC" lines from the UART byte stream into
// single events on a valid/ready slot, with error, overflow and line timeout.
module conn_event_decoder
  import conn_monitor_types_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        evt_valid,
  input  logic        evt_ready,
  output logic        evt_type,
  output logic [47:0] evt_mac,
  output logic        err_pulse,
  output logic        ovf_pulse
);

  localparam int TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  conn_decoder_state_t state_q, state_d;
  logic [4:0]          idx_q, idx_d;
  logic                conn_live_q, conn_live_d;
  logic                disc_live_q, disc_live_d;
  conn_event_t         pend_type_q, pend_type_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic [47:0]         mac_q, mac_d;
  logic                evt_valid_q, evt_valid_d;
  conn_event_t         evt_type_q, evt_type_d;
  logic [47:0]         evt_mac_q, evt_mac_d;
  logic                err_q, err_d;
  logic                ovf_q, ovf_d;

  logic [3:0] nibble;
  logic       is_hex;
  logic       byte_v, is_lf, conn_m, disc_m, sep_pos, char_ok;
  logic       line_err, complete;

  hex_ascii_to_nibble u_hex (
    .char_i   (rx_data),
    .nibble_o (nibble),
    .is_hex_o (is_hex)
  );

  // CR is invisible to the decoder, including the idle timer.
  assign byte_v  = rx_valid && (rx_data != ASCII_CR);
  assign is_lf   = (rx_data == ASCII_LF);
  assign conn_m  = conn_live_q && (idx_q < 5'd5) && (rx_data == kw_conn_char(idx_q[2:0]));
  assign disc_m  = disc_live_q && (idx_q < 5'd4) && (rx_data == kw_disc_char(idx_q[2:0]));
  assign sep_pos = is_sep_pos(idx_q);
  assign char_ok = sep_pos ? (rx_data == ASCII_COLON) : is_hex;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    conn_live_d = conn_live_q;
    disc_live_d = disc_live_q;
    pend_type_d = pend_type_q;
    tmo_d       = tmo_q;
    mac_d       = mac_q;
    evt_valid_d = evt_valid_q;
    evt_type_d  = evt_type_q;
    evt_mac_d   = evt_mac_q;
    err_d       = 1'b0;
    ovf_d       = 1'b0;
    line_err    = 1'b0;
    complete    = 1'b0;

    if (byte_v) begin
      tmo_d = '0;
      case (state_q)
        D_IDLE: begin
          if (rx_data == ASCII_PLUS) begin
            state_d     = D_KEYWORD;
            idx_d       = 5'd0;
            conn_live_d = 1'b1;
            disc_live_d = 1'b1;
          end else if (!is_lf) begin
            state_d = D_DISCARD;
          end
        end
        D_KEYWORD: begin
          if (conn_m && idx_q == 5'd4) begin
            state_d = D_MAC;
            idx_d   = 5'd0;
            mac_d   = '0;
          end else if (disc_m && idx_q == 5'd3) begin
            state_d     = D_EOL;
            pend_type_d = EVT_DISCONNECT;
            mac_d       = '0;
          end else if (!conn_m && !disc_m) begin
            line_err = 1'b1;
          end else begin
            idx_d       = idx_q + 5'd1;
            conn_live_d = conn_m;
            disc_live_d = disc_m;
          end
        end
        D_MAC: begin
          if (char_ok) begin
            if (!sep_pos) mac_d = {mac_q[43:0], nibble};
            if (idx_q == 5'(MAC_CHARS - 1)) begin
              state_d     = D_EOL;
              pend_type_d = EVT_CONNECT;
            end else begin
              idx_d = idx_q + 5'd1;
            end
          end else begin
            line_err = 1'b1;
          end
        end
        D_EOL: begin
          if (is_lf) begin
            complete = 1'b1;
            state_d  = D_IDLE;
          end else begin
            line_err = 1'b1;
          end
        end
        D_DISCARD: begin
          if (is_lf) state_d = D_IDLE;
        end
        default: state_d = D_IDLE;
      endcase

      if (line_err) begin
        err_d   = 1'b1;
        state_d = is_lf ? D_IDLE : D_DISCARD;
        mac_d   = '0;
      end
    end else if (state_q != D_IDLE) begin
      // A byte in the expiry cycle takes the branch above, so it always wins.
      if (tmo_q == TMO_LAST) begin
        state_d = D_IDLE;
        tmo_d   = '0;
        err_d   = (state_q != D_DISCARD);
        mac_d   = '0;
      end else begin
        tmo_d = tmo_q + TMO_W'(1);
      end
    end

    // Output slot: retire on handshake, then load or drop a completed event.
    if (evt_valid_q && evt_ready) begin
      evt_valid_d = 1'b0;
      evt_type_d  = EVT_CONNECT;
      evt_mac_d   = '0;
    end
    if (complete) begin
      if (!evt_valid_q || evt_ready) begin
        evt_valid_d = 1'b1;
        evt_type_d  = pend_type_q;
        evt_mac_d   = (pend_type_q == EVT_DISCONNECT) ? 48'h0 : mac_q;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= D_IDLE;
      idx_q       <= '0;
      conn_live_q <= 1'b0;
      disc_live_q <= 1'b0;
      pend_type_q <= EVT_CONNECT;
      tmo_q       <= '0;
      evt_valid_q <= 1'b0;
      evt_type_q  <= EVT_CONNECT;
      evt_mac_q   <= '0;
      err_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      conn_live_q <= conn_live_d;
      disc_live_q <= disc_live_d;
      pend_type_q <= pend_type_d;
      tmo_q       <= tmo_d;
      evt_valid_q <= evt_valid_d;
      evt_type_q  <= evt_type_d;
      evt_mac_q   <= evt_mac_d;
      err_q       <= err_d;
      ovf_q       <= ovf_d;
    end
  end

  // Working MAC is rebuilt from zero at every line, so it needs no reset.
  always_ff @(posedge clk) begin
    mac_q <= mac_d;
  end

  assign evt_valid = evt_valid_q;
  assign evt_type  = evt_type_q;
  assign evt_mac   = evt_mac_q;
  assign err_pulse = err_q;
  assign ovf_pulse = ovf_q;

endmodule

// File: tb/tb_conn_event_decoder.sv
// Bench for conn_event_decoder: vector table, timing sequences and random lines
// checked against a line-level reference model.
module tb_conn_event_decoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        evt_valid;
  logic        evt_ready;
  logic        evt_type;
  logic [47:0] evt_mac;
  logic        err_pulse;
  logic        ovf_pulse;

  conn_event_decoder #(.TIMEOUT_CYCLES(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_type  (evt_type),
    .evt_mac   (evt_mac),
    .err_pulse (err_pulse),
    .ovf_pulse (ovf_pulse)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  // ---------------- reference model (whole-line judgement) ----------------
  typedef struct { logic typ; logic [47:0] mac; } ev_t;
  ev_t         exp_q[$];
  logic [7:0]  line_q[$];
  int          model_err = 0;
  bit          rand_mode = 0;

  function automatic int hexval(input logic [7:0] c);
    if (c >= "0" && c <= "9") return int'(c - "0");
    if (c >= "A" && c <= "F") return int'(c - "A") + 10;
    if (c >= "a" && c <= "f") return int'(c - "a") + 10;
    return -1;
  endfunction

  // kind: 0 = silent, 1 = error, 2 = connect, 3 = disconnect
  function automatic void judge(input logic [7:0] ln[$], output int kind, output logic [47:0] mac);
    string pfx = "+CONN:";
    string dsc = "+DISC";
    int    v;
    kind = 0;
    mac  = '0;
    if (ln.size() == 0 || ln[0] != "+") return;
    kind = 1;
    if (ln.size() == 5) begin
      for (int i = 0; i < 5; i++) if (ln[i] != dsc[i]) return;
      kind = 3;
      return;
    end
    if (ln.size() != 23) return;
    for (int i = 0; i < 6; i++) if (ln[i] != pfx[i]) return;
    for (int p = 0; p < 17; p++) begin
      if (p % 3 == 2) begin
        if (ln[6+p] != ":") return;
      end else begin
        v = hexval(ln[6+p]);
        if (v < 0) return;
        mac = mac * 16 + 48'(v);
      end
    end
    kind = 2;
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    int          kind;
    logic [47:0] m;
    ev_t         e;
    if (b == 8'h0D) return;
    if (b == 8'h0A) begin
      judge(line_q, kind, m);
      line_q.delete();
      if (kind == 1) model_err++;
      if (kind == 2) begin e.typ = 1'b0; e.mac = m; exp_q.push_back(e); end
      if (kind == 3) begin e.typ = 1'b1; e.mac = '0; exp_q.push_back(e); end
    end else begin
      line_q.push_back(b);
    end
  endfunction

  // ---------------- output monitor ----------------
  int          mon_evt, mon_err, mon_ovf;
  logic        last_type;
  logic [47:0] last_mac;

  always @(negedge clk) begin
    if (evt_valid && evt_ready) begin
      mon_evt++;
      last_type = evt_type;
      last_mac  = evt_mac;
      if (rand_mode) begin
        if (exp_q.size() == 0) begin
          check("rand_unexpected_evt", 64'(evt_mac), 64'hdead);
        end else begin
          check("rand_evt_type", 64'(evt_type), 64'(exp_q[0].typ));
          check("rand_evt_mac", 64'(evt_mac), 64'(exp_q[0].mac));
          void'(exp_q.pop_front());
        end
      end
    end
    if (err_pulse) mon_err++;
    if (ovf_pulse) mon_ovf++;
  end

  task automatic clr_mon();
    mon_evt = 0; mon_err = 0; mon_ovf = 0; last_type = 1'b0; last_mac = '0;
  endtask

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    if (rand_mode) model_byte(b);
    tick();
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string       line;
    int          n_evt;
    logic        typ;
    logic [47:0] mac;
    int          n_err;
  } vec_t;
  vec_t tbl[13];

  logic [7:0] gen_q[$];
  string      hexc = "0123456789ABCDEFabcdef";

  task automatic gen_line();
    int k;
    gen_q.delete();
    k = $urandom_range(0, 6);
    if (k == 1 || k == 4) begin
      gen_q = '{"+", "D", "I", "S", "C"};
      if (k == 4) gen_q.push_back(8'($urandom_range(8'h21, 8'h7E)));
    end else if (k == 2) begin
      gen_q = '{"O", "K"};
    end else if (k == 5) begin
      gen_q = '{"+", "C", "O", "N"};
    end else begin
      gen_q = '{"+", "C", "O", "N", "N", ":"};
      for (int p = 0; p < 17; p++)
        gen_q.push_back((p % 3 == 2) ? 8'h3A : 8'(hexc[$urandom_range(0, 21)]));
      if (k == 3) gen_q[$urandom_range(1, 22)] = 8'($urandom_range(8'h21, 8'h7E));
      if (k == 6) repeat ($urandom_range(1, 3)) void'(gen_q.pop_back());
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{"+CONN:A1:b2:C3:d4:E5:F6\015\n", 1, 1'b0, 48'hA1B2C3D4E5F6, 0};
    tbl[1]  = '{"OK\015\n",                     0, 1'b0, 48'h0,            0};
    tbl[2]  = '{"+DISC\n",                      1, 1'b1, 48'h0,            0};
    tbl[3]  = '{"+CONN:A1:B2-C3:D4:E5:F6\n",    0, 1'b0, 48'h0,            1};
    tbl[4]  = '{"+conn:00:00:00:00:00:00\n",    0, 1'b0, 48'h0,            1};
    tbl[5]  = '{"+DISCX\n",                     0, 1'b0, 48'h0,            1};
    tbl[6]  = '{"+\n",                          0, 1'b0, 48'h0,            1};
    tbl[7]  = '{"+CONN:00:11:22:33:44:5G\n",    0, 1'b0, 48'h0,            1};
    tbl[8]  = '{"+CONN:FF:FF:FF:FF:FF:FF\n",    1, 1'b0, 48'hFFFFFFFFFFFF, 0};
    tbl[9]  = '{"\n",                           0, 1'b0, 48'h0,            0};
    tbl[10] = '{"+CONN:12:34:56:78:9a:bc\n",    1, 1'b0, 48'h123456789ABC, 0};
    tbl[11] = '{"+DIS\n",                       0, 1'b0, 48'h0,            1};
    tbl[12] = '{"+CONN:12:34:56:78:9a:bcd\n",   0, 1'b0, 48'h0,            1};

    rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; evt_ready = 1'b1;
    clr_mon();
    repeat (3) tick();
    check("rst_evt_valid", 64'(evt_valid), 64'd0);
    check("rst_evt_type",  64'(evt_type),  64'd0);
    check("rst_evt_mac",   64'(evt_mac),   64'd0);
    check("rst_err",       64'(err_pulse), 64'd0);
    check("rst_ovf",       64'(ovf_pulse), 64'd0);
    rst_n = 1'b1;
    tick();

    // table vectors
    for (int i = 0; i < 13; i++) begin
      clr_mon();
      send_str(tbl[i].line);
      repeat (2) tick();
      check($sformatf("tbl%0d_nevt", i), 64'(mon_evt),   64'(tbl[i].n_evt));
      check($sformatf("tbl%0d_type", i), 64'(last_type), 64'(tbl[i].typ));
      check($sformatf("tbl%0d_mac", i),  64'(last_mac),  64'(tbl[i].mac));
      check($sformatf("tbl%0d_nerr", i), 64'(mon_err),   64'(tbl[i].n_err));
    end
    check("tbl_novf", 64'(mon_ovf), 64'd0);

    // event timing: valid exactly one cycle after LF
    clr_mon();
    send_str("+CONN:A1:b2:C3:d4:E5:F6\015");
    check("lat_pre_lf", 64'(evt_valid), 64'd0);
    send_byte(8'h0A);
    check("lat_valid", 64'(evt_valid), 64'd1);
    check("lat_type",  64'(evt_type),  64'd0);
    check("lat_mac",   64'(evt_mac),   64'hA1B2C3D4E5F6);
    tick();
    check("lat_drop",  64'(evt_valid), 64'd0);
    check("lat_noerr", 64'(mon_err),   64'd0);

    // error pulse timing on a bad separator
    clr_mon();
    send_str("+CONN:A1:B2");
    send_byte("-");
    check("err_at_dash", 64'(err_pulse), 64'd1);
    tick();
    check("err_one_cycle", 64'(err_pulse), 64'd0);
    send_str("C3\n+DISC");
    send_byte(8'h0A);
    check("err_disc_valid", 64'(evt_valid), 64'd1);
    check("err_disc_type",  64'(evt_type),  64'd1);
    check("err_disc_mac",   64'(evt_mac),   64'd0);
    tick();
    check("err_nevt", 64'(mon_evt), 64'd1);
    check("err_nerr", 64'(mon_err), 64'd1);

    // overflow with slot held
    evt_ready = 1'b0;
    send_str("+CONN:01:23:45:67:89:AB\n");
    check("ovf_held_valid", 64'(evt_valid), 64'd1);
    send_str("+DISC");
    send_byte(8'h0A);
    check("ovf_pulse",      64'(ovf_pulse), 64'd1);
    check("ovf_keep_valid", 64'(evt_valid), 64'd1);
    check("ovf_keep_type",  64'(evt_type),  64'd0);
    check("ovf_keep_mac",   64'(evt_mac),   64'h0123456789AB);
    tick();
    check("ovf_one_cycle",  64'(ovf_pulse), 64'd0);
    check("ovf_still_held", 64'(evt_valid), 64'd1);
    evt_ready = 1'b1;
    tick();
    check("ovf_release", 64'(evt_valid), 64'd0);

    // timeout, with a CR in the gap that must not restart the timer
    clr_mon();
    send_str("+CONN:A1");
    repeat (8) tick();
    send_byte(8'h0D);
    repeat (6) tick();
    check("tmo_early", 64'(err_pulse), 64'd0);
    tick();
    check("tmo_err", 64'(err_pulse), 64'd1);
    tick();
    check("tmo_err_one", 64'(err_pulse), 64'd0);
    send_str("+CONN:0F:1E:2D:3C:4B:5A\n");
    check("tmo_next_valid", 64'(evt_valid), 64'd1);
    check("tmo_next_mac",   64'(evt_mac),   64'h0F1E2D3C4B5A);
    tick();

    // byte arriving in the expiry cycle wins
    clr_mon();
    send_str("+CONN:A1");
    repeat (15) tick();
    send_str(":B2:C3:D4:E5:F6\n");
    check("tmo_win_mac", 64'(evt_mac), 64'hA1B2C3D4E5F6);
    tick();
    check("tmo_win_nevt", 64'(mon_evt), 64'd1);
    check("tmo_win_noerr", 64'(mon_err), 64'd0);

    // stalled discarded line times out silently
    clr_mon();
    send_str("OK");
    repeat (20) tick();
    send_str("+DISC\n");
    tick();
    check("disc_tmo_noerr", 64'(mon_err), 64'd0);
    check("disc_tmo_nevt",  64'(mon_evt), 64'd1);

    // reset mid-MAC with an event held
    evt_ready = 1'b0;
    send_str("+CONN:77:66:55:44:33:22\n");
    send_str("+CONN:11:2");
    rst_n = 1'b0;
    tick();
    check("mrst_valid", 64'(evt_valid), 64'd0);
    check("mrst_type",  64'(evt_type),  64'd0);
    check("mrst_mac",   64'(evt_mac),   64'd0);
    check("mrst_err",   64'(err_pulse), 64'd0);
    check("mrst_ovf",   64'(ovf_pulse), 64'd0);
    rst_n = 1'b1;
    evt_ready = 1'b1;
    clr_mon();
    send_str("+CONN:DE:AD:BE:EF:00:01\n");
    check("mrst_next_valid", 64'(evt_valid), 64'd1);
    check("mrst_next_mac",   64'(evt_mac),   64'hDEADBEEF0001);
    tick();
    check("mrst_next_noerr", 64'(mon_err), 64'd0);

    // randomized lines against the reference model
    clr_mon();
    exp_q.delete();
    line_q.delete();
    model_err = 0;
    rand_mode = 1;
    for (int n = 0; n < 200; n++) begin
      gen_line();
      gen_q.push_back(8'h0A);
      foreach (gen_q[j]) begin
        if ($urandom_range(0, 7) == 0) send_byte(8'h0D);
        send_byte(gen_q[j]);
        repeat ($urandom_range(0, 3)) tick();
      end
    end
    repeat (4) tick();
    rand_mode = 0;
    check("rand_leftover_evts", 64'(exp_q.size()), 64'd0);
    check("rand_err_count",     64'(mon_err),      64'(model_err));
    check("rand_no_ovf",        64'(mon_ovf),      64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
